lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 184 ++++++++++++++++++
 tb/tb_lsu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-bus access, stalling the pipe until the response returns.
// Optional macro LSU_MISALIGN_EXC_EN: flag misaligned halfword/word accesses instead of issuing them.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid_i,
  input  logic [3:0]  ls_type_i,
  input  logic [31:0] memory_addr_i,
  input  logic [31:0] store_data_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        stallreq_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;   // 0 byte, 1 half, 2 word
  logic        uns_q, uns_d;
  logic        st_q;
  logic [31:0] addr_q, wdata_q, wdata_d, rdata_q, ext_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic        accept;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misal_q, misal_d;
`endif

  // Undefined encodings collapse to word accesses, keyed on the store bit.
  always_comb begin
    size_d = 2'd2;
    if (!(ls_type_i[3] && ls_type_i[2])) begin
      if (ls_type_i[1:0] == 2'b00) size_d = 2'd0;
      if (ls_type_i[1:0] == 2'b01) size_d = 2'd1;
    end
    uns_d = ~ls_type_i[3] & ls_type_i[2];
    wstrb_d = '0;
    wdata_d = '0;
    if (ls_type_i[3]) begin
      case (size_d)
        2'd0:    begin wstrb_d = 4'b0001 << memory_addr_i[1:0];         wdata_d = {4{store_data_i[7:0]}};  end
        2'd1:    begin wstrb_d = 4'b0011 << {memory_addr_i[1], 1'b0};   wdata_d = {2{store_data_i[15:0]}}; end
        default: begin wstrb_d = 4'b1111;                                wdata_d = store_data_i;            end
      endcase
    end
`ifdef LSU_MISALIGN_EXC_EN
    misal_d = 1'b0;
    if (size_d == 2'd1) misal_d = memory_addr_i[0];
    if (size_d == 2'd2) misal_d = |memory_addr_i[1:0];
`endif
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata_i[7:0];
      2'd1:    lane_b = mem_rdata_i[15:8];
      2'd2:    lane_b = mem_rdata_i[23:16];
      default: lane_b = mem_rdata_i[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      2'd0:    ext_d = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    ext_d = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ext_d = mem_rdata_i;
    endcase
  end

  assign accept = (state_q == S_IDLE) && ls_valid_i;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ls_valid_i) begin
        state_d = S_REQ;
`ifdef LSU_MISALIGN_EXC_EN
        if (misal_d) state_d = S_DONE;
`endif
      end
      S_REQ:   if (mem_gnt_i) state_d = S_WAIT;
      S_WAIT:  if (mem_rvalid_i) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q  <= '0;
      uns_q   <= 1'b0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_EXC_EN
      misal_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        size_q  <= size_d;
        uns_q   <= uns_d;
        st_q    <= ls_type_i[3];
        addr_q  <= memory_addr_i;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        we_q    <= reg_we_i;
        waddr_q <= reg_waddr_i;
`ifdef LSU_MISALIGN_EXC_EN
        misal_q <= misal_d;
`endif
      end
      if (state_q == S_WAIT && mem_rvalid_i) rdata_q <= ext_d;
    end
  end

  always_comb begin
    reg_we_o    = reg_we_i;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = reg_wdata_i;
    stallreq_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wstrb_o = '0;
    mem_wdata_o = '0;
`ifdef LSU_MISALIGN_EXC_EN
    misalign_o  = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (ls_valid_i) begin
        stallreq_o = 1'b1;
        reg_we_o   = 1'b0;
      end
      S_REQ: begin
        stallreq_o  = 1'b1;
        reg_we_o    = 1'b0;
        mem_req_o   = 1'b1;
        mem_we_o    = st_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wstrb_o = wstrb_q;
        mem_wdata_o = wdata_q;
      end
      S_WAIT: begin
        stallreq_o = 1'b1;
        reg_we_o   = 1'b0;
      end
      default: begin
        reg_we_o    = we_q & ~st_q;
        reg_waddr_o = waddr_q;
        reg_wdata_o = rdata_q;
`ifdef LSU_MISALIGN_EXC_EN
        if (misal_q) reg_we_o = 1'b0;
        misalign_o = misal_q;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a transaction-level reference model.
// Define LSU_MISALIGN_EXC_EN for both files to exercise the misalignment build.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid_i;
  logic [3:0]  ls_type_i;
  logic [31:0] memory_addr_i, store_data_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        stallreq_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign_o;
`endif

  int unsigned nchk = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst(rst),
    .ls_valid_i(ls_valid_i), .ls_type_i(ls_type_i),
    .memory_addr_i(memory_addr_i), .store_data_i(store_data_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .reg_wdata_i(reg_wdata_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef LSU_MISALIGN_EXC_EN
    , .misalign_o(misalign_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes straight from the type table.
  function automatic int model_size(input logic [3:0] t);
    case (t)
      4'b0000, 4'b0100, 4'b1000: return 1;
      4'b0001, 4'b0101, 4'b1001: return 2;
      default:                   return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] t, input logic [31:0] a, input logic [31:0] rd);
    int sz = model_size(t);
    int lane = int'(a[1:0]);
    logic [31:0] v;
    if (sz == 1) begin
      v = (rd >> (8 * lane)) & 32'h0000_00FF;
      if (t == 4'b0000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (rd >> (16 * (lane / 2))) & 32'h0000_FFFF;
      if (t == 4'b0001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else v = rd;
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [3:0] t, input logic [31:0] a);
    int sz = model_size(t);
    if (!t[3]) return 4'b0000;
    if (sz == 1) return 4'b0001 << a[1:0];
    if (sz == 2) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [3:0] t, input logic [31:0] d);
    int sz = model_size(t);
    if (!t[3]) return 32'h0;
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic bit model_misal(input logic [3:0] t, input logic [31:0] a);
`ifdef LSU_MISALIGN_EXC_EN
    int sz = model_size(t);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_stall"}, stallreq_o, 0);
    check_eq({tag, "_req"}, mem_req_o, 0);
    check_eq({tag, "_we"}, reg_we_o, reg_we_i);
    check_eq({tag, "_waddr"}, reg_waddr_o, reg_waddr_i);
    check_eq({tag, "_wdata"}, reg_wdata_o, reg_wdata_i);
  endtask

  task automatic run_txn(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int unsigned gd, input int unsigned rdl,
                         input logic we, input logic [4:0] wa);
    bit mis = model_misal(t, a);
    // Cycle 0: accept
    @(negedge clk);
    ls_valid_i = 1'b1; ls_type_i = t; memory_addr_i = a; store_data_i = sd;
    reg_we_i = we; reg_waddr_i = wa; reg_wdata_i = $urandom;
    mem_gnt_i = 1'($urandom); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
    #1;
    check_eq("acc_stall", stallreq_o, 1);
    check_eq("acc_regwe", reg_we_o, 0);
    check_eq("acc_req", mem_req_o, 0);
    if (!mis) begin
      for (int unsigned k = 0; k <= gd; k++) begin
        @(negedge clk);
        memory_addr_i = $urandom; store_data_i = $urandom; reg_we_i = 1'($urandom);
        mem_gnt_i = (k == gd); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
        #1;
        check_eq("req_req", mem_req_o, 1);
        check_eq("req_stall", stallreq_o, 1);
        check_eq("req_regwe", reg_we_o, 0);
        check_eq("req_we", mem_we_o, t[3]);
        check_eq("req_addr", mem_addr_o, {a[31:2], 2'b00});
        check_eq("req_strb", mem_wstrb_o, model_strb(t, a));
        check_eq("req_wdata", mem_wdata_o, model_wdata(t, sd));
      end
      for (int unsigned k = 0; k <= rdl; k++) begin
        @(negedge clk);
        mem_gnt_i = 1'($urandom); mem_rvalid_i = (k == rdl);
        mem_rdata_i = (k == rdl) ? rd : $urandom;
        #1;
        check_eq("wait_req", mem_req_o, 0);
        check_eq("wait_stall", stallreq_o, 1);
        check_eq("wait_regwe", reg_we_o, 0);
      end
    end
    // DONE: ls_valid_i stays high and must be ignored
    @(negedge clk);
    mem_gnt_i = 1'($urandom); mem_rvalid_i = 1'($urandom); mem_rdata_i = $urandom;
    reg_we_i = 1'($urandom);
    #1;
    check_eq("done_stall", stallreq_o, 0);
    check_eq("done_req", mem_req_o, 0);
    check_eq("done_regwe", reg_we_o, (mis || t[3]) ? 1'b0 : we);
    if (!mis && !t[3]) begin
      check_eq("done_waddr", reg_waddr_o, wa);
      check_eq("done_wdata", reg_wdata_o, model_load(t, a, rd));
    end
`ifdef LSU_MISALIGN_EXC_EN
    check_eq("done_misal", misalign_o, mis);
`endif
    @(negedge clk);
    ls_valid_i = 1'b0; reg_we_i = 1'($urandom); reg_waddr_i = 5'($urandom); reg_wdata_i = $urandom;
    #1;
    check_idle("post");
  endtask

  initial begin
    logic [3:0] t;
    rst = 1'b1; ls_valid_i = 1'b0; ls_type_i = '0; memory_addr_i = '0; store_data_i = '0;
    reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'h1234_5678;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_idle("rst");
    check_eq("rst_bus", {mem_we_o, mem_addr_o[30:0]} | {28'h0, mem_wstrb_o} | mem_wdata_o, 0);
`ifdef LSU_MISALIGN_EXC_EN
    check_eq("rst_misal", misalign_o, 0);
`endif
    @(negedge clk); rst = 1'b0;

    run_txn(4'b0010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b1, 5'd3);
    run_txn(4'b0000, 32'h0000_1003, 32'h0, 32'h8000_0000, 1, 2, 1'b1, 5'd9);
    run_txn(4'b0100, 32'h0000_1003, 32'h0, 32'h8000_0000, 0, 1, 1'b1, 5'd10);
    run_txn(4'b1001, 32'h0000_2002, 32'h0000_ABCD, 32'hFFFF_FFFF, 2, 0, 1'b1, 5'd11);
`ifdef LSU_MISALIGN_EXC_EN
    run_txn(4'b0010, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b1, 5'd12);
`endif

    // Grant held off, then reset lands in WAIT and a late response follows
    run_txn_abort();

    for (int i = 0; i < 200; i++) begin
      t = 4'($urandom);
      run_txn(t, $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  task automatic run_txn_abort();
    @(negedge clk);
    ls_valid_i = 1'b1; ls_type_i = 4'b0010; memory_addr_i = 32'h0000_4008;
    reg_we_i = 1'b1; reg_waddr_i = 5'd5; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check_eq("hold_req", mem_req_o, 1);
      check_eq("hold_stall", stallreq_o, 1);
      check_eq("hold_addr", mem_addr_o, 32'h0000_4008);
      check_eq("hold_we", mem_we_o, 0);
    end
    @(negedge clk); mem_gnt_i = 1'b1;
    @(negedge clk); mem_gnt_i = 1'b0; #1;
    check_eq("abort_wait_stall", stallreq_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ls_valid_i = 1'b0; reg_we_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #1;
    check_idle("abort0");
    check_eq("abort0_addr", mem_addr_o, 0);
    @(negedge clk);
    mem_rvalid_i = 1'b0; #1;
    check_idle("abort1");
  endtask

endmodule
